// File: rtl/fast_inlier_counter_pkg.sv
// rtl/fast_inlier_counter_pkg.sv - ransac_fixed package: Q16.16 fixed type, inlier FSM states, saturating abs.
package ransac_fixed;

    localparam int FIXED_BITS      = 32;
    localparam int FIXED_FRAC_BITS = 16;

    typedef logic signed [FIXED_BITS-1:0] fixed_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_BITS-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_BITS-1){1'b0}}};

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } inlier_state_t;

    // The most-negative code has no positive twin, so it clamps to FIXED_MAX.
    function automatic fixed_t fixed_abs_sat(input fixed_t value);
        fixed_t result;
        if (value == FIXED_MIN) begin
            result = FIXED_MAX;
        end else if (value[FIXED_BITS-1]) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/fast_inlier_counter_fixed_abs_compare.sv
// rtl/fast_inlier_counter_fixed_abs_compare.sv - registered saturating |distance| <= threshold compare.
module fixed_abs_compare
    import ransac_fixed::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   in_valid,
    input  logic   in_last,
    input  fixed_t distance,
    input  fixed_t threshold,
    output logic   out_valid,
    output logic   out_last,
    output logic   out_hit
);

    fixed_t abs_value;
    fixed_t bound;
    logic   valid_d, valid_q;
    logic   last_d, last_q;
    logic   hit_d, hit_q;

    always_comb begin
        abs_value = fixed_abs_sat(distance);
        // A negative bound collapses to zero so only an exact zero distance qualifies.
        bound     = threshold[FIXED_BITS-1] ? '0 : threshold;
        valid_d   = in_valid;
        last_d    = in_valid & in_last;
        hit_d     = in_valid & (abs_value <= bound);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            hit_q   <= hit_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_hit   = hit_q;

endmodule

// File: rtl/fast_inlier_counter.sv
// rtl/fast_inlier_counter.sv - per-hypothesis RANSAC inlier counter with held valid/ready result.
// Optional best-hypothesis tracking under RANSAC_INLIER_BEST_TRACK_EN.
module fast_inlier_counter
    import ransac_fixed::*;
#(
    parameter int count_bits      = 16,
    parameter int hypothesis_bits = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  fixed_t                     distance,
    input  logic                       distance_valid,
    input  logic                       distance_last,
    input  logic [hypothesis_bits-1:0] hypothesis_id,
    input  fixed_t                     threshold,
    output logic [count_bits-1:0]      result_count,
    output logic [hypothesis_bits-1:0] result_id,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       overrun
`ifdef RANSAC_INLIER_BEST_TRACK_EN
    ,
    input  logic                       best_clear,
    output logic [count_bits-1:0]      best_count,
    output logic [hypothesis_bits-1:0] best_id
`endif
);

    inlier_state_t              state_d, state_q;
    fixed_t                     threshold_d, threshold_q;
    logic [hypothesis_bits-1:0] id_d, id_q;
    fixed_t                     threshold_eff;
    logic [hypothesis_bits-1:0] id_eff;

    // The first valid of a set uses the live inputs; later samples use the latched copies.
    always_comb begin
        state_d       = state_q;
        threshold_d   = threshold_q;
        id_d          = id_q;
        threshold_eff = (state_q == IDLE) ? threshold : threshold_q;
        id_eff        = (state_q == IDLE) ? hypothesis_id : id_q;
        case (state_q)
            IDLE: begin
                if (distance_valid) begin
                    threshold_d = threshold;
                    id_d        = hypothesis_id;
                    if (!distance_last) begin
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (distance_valid && distance_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic                       s1_valid, s1_last, s1_hit;
    logic [hypothesis_bits-1:0] s1_id_d, s1_id_q;

    fixed_abs_compare u_abs_compare (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (distance_valid),
        .in_last   (distance_last),
        .distance  (distance),
        .threshold (threshold_eff),
        .out_valid (s1_valid),
        .out_last  (s1_last),
        .out_hit   (s1_hit)
    );

    // The id rides alongside stage 1 so a set starting right after a last cannot clobber it.
    assign s1_id_d = distance_valid ? id_eff : s1_id_q;

    logic [count_bits-1:0]      counter_d, counter_q;
    logic [count_bits-1:0]      count_sum;
    logic                       new_result;
    logic [count_bits-1:0]      result_count_d, result_count_q;
    logic [hypothesis_bits-1:0] result_id_d, result_id_q;
    logic                       result_valid_d, result_valid_q;
    logic                       overrun_d, overrun_q;

    always_comb begin
        count_sum      = (&counter_q) ? counter_q
                                      : counter_q + {{(count_bits-1){1'b0}}, s1_hit};
        new_result     = s1_valid & s1_last;
        counter_d      = counter_q;
        result_count_d = result_count_q;
        result_id_d    = result_id_q;
        if (s1_valid) begin
            counter_d = s1_last ? '0 : count_sum;
        end
        if (new_result) begin
            result_count_d = count_sum;
            result_id_d    = s1_id_q;
        end
        result_valid_d = new_result | (result_valid_q & ~result_ready);
        overrun_d      = overrun_q | (new_result & result_valid_q & ~result_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            threshold_q    <= '0;
            id_q           <= '0;
            s1_id_q        <= '0;
            counter_q      <= '0;
            result_count_q <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            threshold_q    <= threshold_d;
            id_q           <= id_d;
            s1_id_q        <= s1_id_d;
            counter_q      <= counter_d;
            result_count_q <= result_count_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign result_count = result_count_q;
    assign result_id    = result_id_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q == COUNTING);

`ifdef RANSAC_INLIER_BEST_TRACK_EN
    logic [count_bits-1:0]      best_count_d, best_count_q;
    logic [hypothesis_bits-1:0] best_id_d, best_id_q;

    // Strictly-greater keeps the earlier hypothesis on ties; clear beats a same-cycle update.
    always_comb begin
        best_count_d = best_count_q;
        best_id_d    = best_id_q;
        if (best_clear) begin
            best_count_d = '0;
            best_id_d    = '0;
        end else if (new_result && (count_sum > best_count_q)) begin
            best_count_d = count_sum;
            best_id_d    = s1_id_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_count_q <= '0;
            best_id_q    <= '0;
        end else begin
            best_count_q <= best_count_d;
            best_id_q    <= best_id_d;
        end
    end

    assign best_count = best_count_q;
    assign best_id    = best_id_q;
`endif

endmodule
